instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the control unit.
//  Holds PC and instruction register (IR); fetches 16-bit words via a req/ack memory handshake.
//  Presents decoded opcode/reg_s/acc_s/target fields to the control unit.
//  Updates PC on the control unit's advance, branch and ret commands.
// PARAMETERS
//  AW        10   program address width (PC, mem_addr, targets)
//  RESET_PC  0    PC value loaded on reset and on restart from HALT
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   begin fetching (IDLE/HALT only)
//  mem_req      out  1   fetch request; held high until mem_ack
//  mem_addr     out  AW  fetch address (= pc)
//  mem_rdata    in   16  instruction word; valid when mem_ack=1
//  mem_ack      in   1   one-cycle read acknowledge
//  advance      in   1   control unit consumed current IR; compute next PC
//  branch       in   1   taken branch/jmp: next PC = target (qualified by advance)
//  ret          in   1   return: next PC = ret_addr (qualified by advance)
//  ret_addr     in   AW  return address popped from stack
//  instr_valid  out  1   IR holds a fetched, unconsumed instruction
//  opcode       out  6   IR[15:10]
//  reg_s        out  1   IR[9]
//  acc_s        out  1   IR[8]
//  target       out  AW  IR[9:0] zero-extended/truncated to AW
//  pc           out  AW  address of the instruction in IR
//  link_addr    out  AW  pc+1 mod 2^AW (pushed on jmp)
//  halted       out  1   HALT opcode (6'h00) consumed
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, IR=16'h0000, mem_req=0, instr_valid=0, halted=0.
//  FSM states: IDLE, FETCH, READY, HALT.
//   IDLE:  start=1 -> FETCH (pc unchanged); otherwise stay.
//   FETCH: mem_req=1, mem_addr=pc.
//          mem_ack=1 -> IR<=mem_rdata -> READY; instr_valid=1 from the next cycle.
//          Otherwise stay; no timeout.
//   READY: instr_valid=1; IR and pc held stable until advance.
//          On advance:
//            opcode==6'h00 -> HALT (pc unchanged).
//            else next pc: ret ? ret_addr : branch ? target : pc+1 (wraps 2^AW-1 -> 0); go FETCH.
//   HALT:  halted=1, instr_valid=0; start=1 -> pc<=RESET_PC, halted<=0, go FETCH.
//  Priority: ret over branch (ret also arrives with branch=1).
//  branch/ret without advance are ignored.
//  advance outside READY is ignored.
//  mem_ack outside FETCH is ignored; IR is not written.
//  start outside IDLE/HALT is ignored.
//  Latency: advance -> mem_req high next cycle; mem_ack -> instr_valid high next cycle.
//   Minimum 2 cycles per instruction with zero-wait memory.
//  opcode/reg_s/acc_s/target/link_addr are combinational from IR/pc; they are meaningful only while instr_valid=1.
//  Reset mid-fetch: mem_req drops immediately (async); a late mem_ack after reset is ignored.
// TESTING
//  1. Reset, start; memory at 0 returns 16'h2800 with ack after 2 cycles
//     -> mem_req held 3 cycles; instr_valid=1, opcode=6'h0A, pc=0.
//  2. advance with branch=0, ret=0 at pc=5 -> next mem_addr=6, link_addr before advance=6.
//  3. IR=16'h1E2A (op 6'h07), advance+branch -> next mem_addr=10'h22A.
//     Repeat with ret=1, ret_addr=10'h033 -> mem_addr=10'h033.
//  4. pc=10'h3FF, plain advance -> mem_addr=0 (wrap).
//  5. Fetch 16'h0000, advance -> halted=1, instr_valid=0, no mem_req.
//     start -> mem_addr=RESET_PC, halted=0.
//  6. Assert reset while mem_req=1 awaiting ack -> mem_req=0 same cycle.
//     A late ack is ignored; state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds PC and IR, fetches 16-bit words over a req/ack
// handshake and presents decoded fields to the control unit.
module instr_fetch_unit #(
    parameter int             AW       = 10,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_ack,
    input  logic          advance,
    input  logic          branch,
    input  logic          ret,
    input  logic [AW-1:0] ret_addr,
    output logic          instr_valid,
    output logic [5:0]    opcode,
    output logic          reg_s,
    output logic          acc_s,
    output logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] link_addr,
    output logic          halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_READY = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [5:0] OP_HALT = 6'h00;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // The branch target field is IR[9:0], resized to the program address width.
    generate
        if (AW > 10) begin : g_tgt_ext
            assign target = {{(AW-10){1'b0}}, ir_q[9:0]};
        end else if (AW == 10) begin : g_tgt_eq
            assign target = ir_q[9:0];
        end else begin : g_tgt_trunc
            assign target = ir_q[AW-1:0];
        end
    endgenerate

    assign opcode    = ir_q[15:10];
    assign reg_s     = ir_q[9];
    assign acc_s     = ir_q[8];
    assign pc        = pc_q;
    assign mem_addr  = pc_q;
    assign link_addr = pc_q + AW'(1);

    // Status outputs decode straight from the state register so an async reset
    // drops mem_req in the same cycle.
    assign mem_req     = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_READY);
    assign halted      = (state_q == S_HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (advance) begin
                    if (opcode == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        // ret arrives together with branch, so it must win.
                        if (ret)         pc_d = ret_addr;
                        else if (branch) pc_d = target;
                        else             pc_d = link_addr;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: hand-computed fetch, branch, ret, wrap,
// halt/restart and reset-mid-fetch scenarios.
module tb_instr_fetch_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata;
    logic          mem_ack;
    logic          advance;
    logic          branch;
    logic          ret;
    logic [AW-1:0] ret_addr;
    logic          instr_valid;
    logic [5:0]    opcode;
    logic          reg_s;
    logic          acc_s;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic [AW-1:0] link_addr;
    logic          halted;

    int n_vec = 0;
    int n_bad = 0;
    int req_cycles;

    instr_fetch_unit #(.AW(AW), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .advance(advance), .branch(branch), .ret(ret), .ret_addr(ret_addr),
        .instr_valid(instr_valid), .opcode(opcode), .reg_s(reg_s), .acc_s(acc_s),
        .target(target), .pc(pc), .link_addr(link_addr), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Serve the pending fetch: hold off `waits` cycles, then ack with `word`.
    task automatic serve(input logic [15:0] word, input int waits, output int reqs);
        reqs = 0;
        for (int i = 0; i < waits; i++) begin
            if (mem_req) reqs++;
            tick();
        end
        if (mem_req) reqs++;
        mem_ack   = 1'b1;
        mem_rdata = word;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
    endtask

    task automatic adv(input logic br, input logic rt, input logic [AW-1:0] ra);
        advance  = 1'b1;
        branch   = br;
        ret      = rt;
        ret_addr = ra;
        tick();
        advance  = 1'b0;
        branch   = 1'b0;
        ret      = 1'b0;
        ret_addr = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_rdata = 16'h0; mem_ack = 1'b0;
        advance = 1'b0; branch = 1'b0; ret = 1'b0; ret_addr = '0;
        tick(); tick();
        chk("rst_req",   mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halt",  halted, 0);
        chk("rst_pc",    pc, 0);
        chk("rst_op",    opcode, 0);
        reset = 1'b0;
        tick();
        chk("idle_req", mem_req, 0);

        // 1: first fetch, ack after 2 wait cycles
        start = 1'b1; tick(); start = 1'b0;
        serve(16'h2800, 2, req_cycles);
        chk("t1_req_cycles", req_cycles, 3);
        chk("t1_valid", instr_valid, 1);
        chk("t1_op", opcode, 6'h0A);
        chk("t1_pc", pc, 0);
        chk("t1_req_off", mem_req, 0);

        // branch without advance must be ignored
        branch = 1'b1; ret = 1'b1; ret_addr = 10'h155; tick();
        branch = 1'b0; ret = 1'b0; ret_addr = '0;
        chk("nadv_valid", instr_valid, 1);
        chk("nadv_pc", pc, 0);

        // walk to pc=5: plain advance to 1, then branch to 5
        adv(1'b0, 1'b0, '0);
        chk("adv_req", mem_req, 1);
        chk("adv_addr", mem_addr, 1);
        // advance while fetching is ignored
        adv(1'b1, 1'b0, '0);
        chk("fetch_adv_addr", mem_addr, 1);
        chk("fetch_adv_req", mem_req, 1);
        serve(16'h2805, 0, req_cycles);
        chk("tgt5", target, 5);
        adv(1'b1, 1'b0, '0);
        chk("br5_addr", mem_addr, 5);

        // 2: plain advance at pc=5
        serve(16'h2800, 1, req_cycles);
        chk("t2_pc", pc, 5);
        chk("t2_link", link_addr, 6);
        adv(1'b0, 1'b0, '0);
        chk("t2_addr", mem_addr, 6);

        // 3: branch then ret
        serve(16'h1E2A, 0, req_cycles);
        chk("t3_op", opcode, 6'h07);
        chk("t3_regs", reg_s, 1);
        chk("t3_accs", acc_s, 0);
        chk("t3_tgt", target, 10'h22A);
        adv(1'b1, 1'b0, '0);
        chk("t3_br_addr", mem_addr, 10'h22A);
        serve(16'h1E2A, 0, req_cycles);
        adv(1'b1, 1'b1, 10'h033);
        chk("t3_ret_addr", mem_addr, 10'h033);

        // 4: wrap from 0x3FF
        serve(16'h2BFF, 0, req_cycles);
        adv(1'b1, 1'b0, '0);
        chk("t4_to3ff", mem_addr, 10'h3FF);
        serve(16'h2800, 0, req_cycles);
        chk("t4_link", link_addr, 0);
        adv(1'b0, 1'b0, '0);
        chk("t4_wrap", mem_addr, 0);

        // 5: HALT and restart
        serve(16'h0000, 0, req_cycles);
        chk("t5_halt_op", opcode, 0);
        adv(1'b0, 1'b0, '0);
        chk("t5_halted", halted, 1);
        chk("t5_valid", instr_valid, 0);
        chk("t5_req", mem_req, 0);
        mem_ack = 1'b1; mem_rdata = 16'hFFFF; tick(); mem_ack = 1'b0;
        chk("t5_ack_ign_op", opcode, 0);
        chk("t5_still_halt", halted, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_restart_halt", halted, 0);
        chk("t5_restart_req", mem_req, 1);
        chk("t5_restart_addr", mem_addr, 0);

        // 6: reset during an outstanding fetch at pc=5
        serve(16'h2805, 0, req_cycles);
        adv(1'b1, 1'b0, '0);
        chk("t6_pre_req", mem_req, 1);
        chk("t6_pre_addr", mem_addr, 5);
        reset = 1'b1;
        #1;
        chk("t6_async_req", mem_req, 0);
        chk("t6_async_pc", pc, 0);
        tick();
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h2C00; tick(); mem_ack = 1'b0;
        chk("t6_late_valid", instr_valid, 0);
        chk("t6_late_req", mem_req, 0);
        chk("t6_late_pc", pc, 0);
        chk("t6_late_op", opcode, 0);
        start = 1'b1; tick(); start = 1'b0;
        serve(16'h2C00, 0, req_cycles);
        chk("t6_again_op", opcode, 6'h0B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
